// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : Hazard inputs and stall/flush controls of pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_use_rs_i;
    logic             id_use_rt_i;
    logic [4:0]       ex_rd_i;
    logic             ex_mem_read_i;
    logic             ex_branch_taken_i;
    logic             ex_mc_start_i;
    logic             halt_req_i;
    logic             resume_i;

    logic             pc_en_o;
    logic             ifid_en_o;
    logic             idex_en_o;
    logic             exmem_en_o;
    logic             ifid_clr_o;
    logic             idex_clr_o;
    logic [1:0]       state_o;
    logic             halted_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_rd_i,
               ex_mem_read_i, ex_branch_taken_i, ex_mc_start_i,
               halt_req_i, resume_i,
        input  pc_en_o, ifid_en_o, idex_en_o, exmem_en_o,
               ifid_clr_o, idex_clr_o, state_o, halted_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_rd_i,
               ex_mem_read_i, ex_branch_taken_i, ex_mc_start_i,
               halt_req_i, resume_i,
        output pc_en_o, ifid_en_o, idex_en_o, exmem_en_o,
               ifid_clr_o, idex_clr_o, state_o, halted_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush sequencer for the five-stage pipeline with stats.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_hazard_ctrl_if.slave hz_io
);

    localparam logic [1:0] c_RUN     = 2'd0;
    localparam logic [1:0] c_MC      = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;
    localparam logic [1:0] c_HALT    = 2'd3;
    localparam logic [7:0] c_MC_LOAD = 8'(MC_LAT - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic w_load_use;
    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en;
    logic w_ifid_clr, w_idex_clr, w_flush, w_halted;

    assign w_load_use = hz_io.ex_mem_read_i && (hz_io.ex_rd_i != 5'd0) &&
                        ((hz_io.id_use_rs_i && (hz_io.id_rs_i == hz_io.ex_rd_i)) ||
                         (hz_io.id_use_rt_i && (hz_io.id_rt_i == hz_io.ex_rd_i)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= c_RUN;
            mc_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    // DONE shares the RUN decode but never restarts the op still sitting in EX.
    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        case (state_q)
            c_RUN, c_DONE: begin
                if (hz_io.halt_req_i) begin
                    state_d = c_HALT;
                end else if (hz_io.ex_branch_taken_i) begin
                    state_d = c_RUN;
                end else if ((state_q == c_RUN) && hz_io.ex_mc_start_i) begin
                    state_d  = c_MC;
                    mc_cnt_d = c_MC_LOAD;
                end else begin
                    state_d = c_RUN;
                end
            end
            c_MC: begin
                mc_cnt_d = mc_cnt_q - 8'd1;
                if (mc_cnt_q <= 8'd1) begin
                    state_d = c_DONE;
                end
            end
            c_HALT: begin
                if (hz_io.resume_i) begin
                    state_d = c_RUN;
                end
            end
        endcase
    end

    always_comb begin
        w_pc_en    = 1'b1;
        w_ifid_en  = 1'b1;
        w_idex_en  = 1'b1;
        w_exmem_en = 1'b1;
        w_ifid_clr = 1'b0;
        w_idex_clr = 1'b0;
        w_flush    = 1'b0;
        w_halted   = 1'b0;
        case (state_q)
            c_RUN, c_DONE: begin
                if (hz_io.halt_req_i) begin
                    w_pc_en    = 1'b0;
                    w_ifid_en  = 1'b0;
                    w_idex_en  = 1'b0;
                    w_exmem_en = 1'b0;
                end else if (hz_io.ex_branch_taken_i) begin
                    w_ifid_clr = 1'b1;
                    w_idex_clr = 1'b1;
                    w_flush    = 1'b1;
                end else if ((state_q == c_RUN) && hz_io.ex_mc_start_i) begin
                    w_pc_en    = 1'b0;
                    w_ifid_en  = 1'b0;
                    w_idex_en  = 1'b0;
                    w_exmem_en = 1'b0;
                end else if (w_load_use) begin
                    w_pc_en    = 1'b0;
                    w_ifid_en  = 1'b0;
                    w_idex_clr = 1'b1;
                end
            end
            c_MC: begin
                w_pc_en    = 1'b0;
                w_ifid_en  = 1'b0;
                w_idex_en  = 1'b0;
                w_exmem_en = 1'b0;
            end
            c_HALT: begin
                w_pc_en    = 1'b0;
                w_ifid_en  = 1'b0;
                w_idex_en  = 1'b0;
                w_exmem_en = 1'b0;
                w_halted   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!w_pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (w_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign hz_io.pc_en_o     = w_pc_en;
    assign hz_io.ifid_en_o   = w_ifid_en;
    assign hz_io.idex_en_o   = w_idex_en;
    assign hz_io.exmem_en_o  = w_exmem_en;
    assign hz_io.ifid_clr_o  = w_ifid_clr;
    assign hz_io.idex_clr_o  = w_idex_clr;
    assign hz_io.state_o     = state_q;
    assign hz_io.halted_o    = w_halted;
    assign hz_io.stall_cnt_o = stall_cnt_q;
    assign hz_io.flush_cnt_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32)) hz ();
    pipe_hazard_ctrl_if #(.CNT_W(3))  hz2 ();

    // Narrow-counter instance shares the same stimulus to exercise saturation.
    assign hz2.id_rs_i           = hz.id_rs_i;
    assign hz2.id_rt_i           = hz.id_rt_i;
    assign hz2.id_use_rs_i       = hz.id_use_rs_i;
    assign hz2.id_use_rt_i       = hz.id_use_rt_i;
    assign hz2.ex_rd_i           = hz.ex_rd_i;
    assign hz2.ex_mem_read_i     = hz.ex_mem_read_i;
    assign hz2.ex_branch_taken_i = hz.ex_branch_taken_i;
    assign hz2.ex_mc_start_i     = hz.ex_mc_start_i;
    assign hz2.halt_req_i        = hz.halt_req_i;
    assign hz2.resume_i          = hz.resume_i;

    pipe_hazard_ctrl #(.MC_LAT(4), .CNT_W(32)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .hz_io (hz)
    );

    pipe_hazard_ctrl #(.MC_LAT(2), .CNT_W(3)) u_sat (
        .clk   (clk),
        .rst   (rst),
        .hz_io (hz2)
    );

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_clr, idex_clr}
    logic [5:0] ctl;
    assign ctl = {hz.pc_en_o, hz.ifid_en_o, hz.idex_en_o, hz.exmem_en_o,
                  hz.ifid_clr_o, hz.idex_clr_o};

    task automatic quiet();
        hz.id_rs_i           = 5'd0;
        hz.id_rt_i           = 5'd0;
        hz.id_use_rs_i       = 1'b0;
        hz.id_use_rt_i       = 1'b0;
        hz.ex_rd_i           = 5'd0;
        hz.ex_mem_read_i     = 1'b0;
        hz.ex_branch_taken_i = 1'b0;
        hz.ex_mc_start_i     = 1'b0;
        hz.halt_req_i        = 1'b0;
        hz.resume_i          = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (ctl !== 6'b111100) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b111100);
        end
        n_checks++;
        if (hz.state_o !== 2'd0 || hz.halted_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got %0d/%b expected 0/0", hz.state_o, hz.halted_o);
        end
        n_checks++;
        if (hz.stall_cnt_o !== 32'd0 || hz.flush_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", hz.stall_cnt_o, hz.flush_cnt_o);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        hz.ex_mem_read_i = 1'b1; hz.ex_rd_i = 5'd5;
        hz.id_rs_i = 5'd5; hz.id_use_rs_i = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b001101) begin
            n_fail++; $display("FAIL lu_rs_ctl: got %b expected %b", ctl, 6'b001101);
        end
        tick();
        quiet();
        #1;
        n_checks++;
        if (ctl !== 6'b111100 || hz.stall_cnt_o !== 32'd1) begin
            n_fail++; $display("FAIL lu_one_bubble: got %b/%0d expected 111100/1", ctl, hz.stall_cnt_o);
        end
        hz.ex_mem_read_i = 1'b1; hz.ex_rd_i = 5'd0;
        hz.id_rs_i = 5'd0; hz.id_use_rs_i = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b111100) begin
            n_fail++; $display("FAIL lu_r0_ctl: got %b expected %b", ctl, 6'b111100);
        end
        tick();
        hz.ex_rd_i = 5'd7; hz.id_rs_i = 5'd7; hz.id_use_rs_i = 1'b0;
        hz.id_rt_i = 5'd7; hz.id_use_rt_i = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b001101) begin
            n_fail++; $display("FAIL lu_rt_ctl: got %b expected %b", ctl, 6'b001101);
        end
        tick();
        hz.id_use_rt_i = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 6'b111100 || hz.stall_cnt_o !== 32'd2) begin
            n_fail++; $display("FAIL lu_unused_src: got %b/%0d expected 111100/2", ctl, hz.stall_cnt_o);
        end
        quiet();
    endtask

    task automatic test_branch();
        apply_reset();
        hz.ex_branch_taken_i = 1'b1;
        hz.ex_mem_read_i = 1'b1; hz.ex_rd_i = 5'd3;
        hz.id_rs_i = 5'd3; hz.id_use_rs_i = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b111111) begin
            n_fail++; $display("FAIL br_ctl: got %b expected %b", ctl, 6'b111111);
        end
        tick();
        quiet();
        #1;
        n_checks++;
        if (hz.flush_cnt_o !== 32'd1 || hz.stall_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL br_cnt: got flush %0d stall %0d expected 1/0", hz.flush_cnt_o, hz.stall_cnt_o);
        end
    endtask

    task automatic test_multicycle();
        logic [1:0] exp_st [6];
        logic [5:0] exp_ctl [6];
        exp_st  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
        exp_ctl = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b111100, 6'b111100};
        apply_reset();
        hz.ex_mc_start_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) hz.ex_mc_start_i = 1'b0;
            #1;
            n_checks++;
            if (hz.state_o !== exp_st[i] || ctl !== exp_ctl[i]) begin
                n_fail++;
                $display("FAIL mc_cycle%0d: got state %0d ctl %b expected state %0d ctl %b",
                         i, hz.state_o, ctl, exp_st[i], exp_ctl[i]);
            end
            tick();
        end
        n_checks++;
        if (hz.stall_cnt_o !== 32'd4 || hz.state_o !== 2'd0) begin
            n_fail++; $display("FAIL mc_stall_cnt: got %0d state %0d expected 4 state 0", hz.stall_cnt_o, hz.state_o);
        end
    endtask

    task automatic test_halt_in_mc();
        apply_reset();
        hz.ex_mc_start_i = 1'b1;
        tick();
        tick();
        hz.halt_req_i = 1'b1;
        #1;
        n_checks++;
        if (hz.state_o !== 2'd1 || ctl !== 6'b000000) begin
            n_fail++; $display("FAIL hmc_in_mc: got state %0d ctl %b expected 1 000000", hz.state_o, ctl);
        end
        tick();
        tick();
        n_checks++;
        if (hz.state_o !== 2'd2 || ctl !== 6'b000000 || hz.halted_o !== 1'b0) begin
            n_fail++; $display("FAIL hmc_done: got state %0d ctl %b halted %b expected 2 000000 0", hz.state_o, ctl, hz.halted_o);
        end
        tick();
        hz.ex_mc_start_i = 1'b0;
        n_checks++;
        if (hz.state_o !== 2'd3 || hz.halted_o !== 1'b1 || ctl !== 6'b000000) begin
            n_fail++; $display("FAIL hmc_halt: got state %0d halted %b ctl %b expected 3 1 000000", hz.state_o, hz.halted_o, ctl);
        end
        hz.halt_req_i = 1'b0;
        hz.resume_i   = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b000000 || hz.halted_o !== 1'b1) begin
            n_fail++; $display("FAIL hmc_resume_cycle: got ctl %b halted %b expected 000000 1", ctl, hz.halted_o);
        end
        tick();
        hz.resume_i = 1'b0;
        #1;
        n_checks++;
        if (hz.state_o !== 2'd0 || hz.halted_o !== 1'b0 || ctl !== 6'b111100) begin
            n_fail++; $display("FAIL hmc_exit: got state %0d halted %b ctl %b expected 0 0 111100", hz.state_o, hz.halted_o, ctl);
        end
        n_checks++;
        if (hz.stall_cnt_o !== 32'd6) begin
            n_fail++; $display("FAIL hmc_stall_cnt: got %0d expected 6", hz.stall_cnt_o);
        end
    endtask

    task automatic test_halt_branch();
        apply_reset();
        hz.halt_req_i = 1'b1;
        hz.ex_branch_taken_i = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL hbr_ctl: got %b expected %b", ctl, 6'b000000);
        end
        tick();
        hz.halt_req_i = 1'b0;
        hz.resume_i = 1'b1;
        #1;
        n_checks++;
        if (hz.state_o !== 2'd3 || hz.flush_cnt_o !== 32'd0 || ctl !== 6'b000000) begin
            n_fail++; $display("FAIL hbr_held: got state %0d flush %0d ctl %b expected 3 0 000000", hz.state_o, hz.flush_cnt_o, ctl);
        end
        tick();
        hz.resume_i = 1'b0;
        #1;
        n_checks++;
        if (hz.state_o !== 2'd0 || ctl !== 6'b111111) begin
            n_fail++; $display("FAIL hbr_reeval: got state %0d ctl %b expected 0 111111", hz.state_o, ctl);
        end
        quiet();
    endtask

    task automatic test_rst_mid_mc();
        apply_reset();
        hz.ex_mc_start_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (hz.state_o !== 2'd1 || hz.stall_cnt_o !== 32'd2) begin
            n_fail++; $display("FAIL rmc_pre: got state %0d stall %0d expected 1 2", hz.state_o, hz.stall_cnt_o);
        end
        hz.ex_mc_start_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (hz.state_o !== 2'd0 || hz.stall_cnt_o !== 32'd0 || hz.flush_cnt_o !== 32'd0 || ctl !== 6'b111100) begin
            n_fail++; $display("FAIL rmc_async: got state %0d stall %0d flush %0d ctl %b expected 0 0 0 111100",
                               hz.state_o, hz.stall_cnt_o, hz.flush_cnt_o, ctl);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        hz.halt_req_i = 1'b1;
        repeat (10) tick();
        hz.halt_req_i = 1'b0;
        hz.resume_i = 1'b1;
        tick();
        hz.resume_i = 1'b0;
        n_checks++;
        if (hz2.stall_cnt_o !== 3'd7) begin
            n_fail++; $display("FAIL sat_stall: got %0d expected 7", hz2.stall_cnt_o);
        end
        n_checks++;
        if (hz.stall_cnt_o !== 32'd11) begin
            n_fail++; $display("FAIL wide_stall: got %0d expected 11", hz.stall_cnt_o);
        end
        hz.ex_branch_taken_i = 1'b1;
        repeat (10) tick();
        hz.ex_branch_taken_i = 1'b0;
        #1;
        n_checks++;
        if (hz2.flush_cnt_o !== 3'd7 || hz.flush_cnt_o !== 32'd10) begin
            n_fail++; $display("FAIL sat_flush: got %0d/%0d expected 7/10", hz2.flush_cnt_o, hz.flush_cnt_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        test_reset();
        test_load_use();
        test_branch();
        test_multicycle();
        test_halt_in_mc();
        test_halt_branch();
        test_rst_mid_mc();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. It drives the enable and clear inputs of the PC register and of the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, taken-branch flushes, fixed-latency multi-cycle EX operations and an external halt/resume request. It also keeps saturating stall and flush statistics counters.

## Interface
- MC_LAT, 4: total stall cycles of a multi-cycle EX op; legal range 2..255.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  the ID instruction actually reads rs / rt.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  the EX instruction is a resolved taken branch or jump.
- ex_mc_start  in  1  the EX instruction is a multi-cycle op; stays high while that op sits in EX.
- halt_req  in  1  level request to freeze the pipeline.
- resume  in  1  single-cycle pulse that leaves HALT.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register enables.
- ifid_clr, idex_clr  out  1 each  synchronous clears (bubble insertion).
- state  out  2  RUN=0, MC=1, DONE=2, HALT=3.
- halted  out  1  high in HALT.
- stall_cnt, flush_cnt  out  CNT_W each  statistics counters.

## Operation
- All control outputs are combinational from state and the current inputs (Mealy). Only state, the MC down-counter and the statistics counters are registered.
- Default (no event): all enables 1, all clears 0.
- load_use = ex_mem_read & (ex_rd != 0) & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd)).
- RUN, evaluated in priority order:
  1. halt_req: pc_en = ifid_en = idex_en = exmem_en = 0; next state HALT. A coincident branch stays held in EX and is re-evaluated after resume.
  2. ex_branch_taken: pc_en = 1 (PC loads target); ifid_clr = idex_clr = 1; flush_cnt increments; stay in RUN. A coincident ex_mc_start is a protocol violation and is ignored.
  3. ex_mc_start: all four enables 0; next state MC; counter loaded with MC_LAT-1.
  4. load_use: pc_en = ifid_en = 0, idex_clr = 1, exmem_en = 1; stay in RUN.
- MC:
  - All four enables 0; halt_req and ex_mc_start are ignored.
  - Counter decrements each cycle.
  - When counter == 1, next state DONE.
- DONE:
  - Behaves as RUN except ex_mc_start is ignored, so the finishing op is not retriggered.
  - Next state is RUN, or HALT if halt_req is high.
- HALT:
  - All four enables 0, clears 0, halted = 1.
  - resume → RUN next cycle. halt_req is ignored while in HALT.
  - If halt_req is still high in RUN, the block re-halts; the requester must drop halt_req.
- stall_cnt increments on every cycle where pc_en = 0, including HALT. Both counters saturate at all-ones.

## Timing
- Reset (asynchronous, immediate):
  - state = RUN, counter = 0, stall_cnt = flush_cnt = 0, halted = 0.
  - Control outputs are then the RUN decode of the live inputs, which is the default with quiet inputs.
- Load-use: exactly 1 bubble cycle.
- Branch flush: 0 stall cycles, 2 instructions squashed.
- Multi-cycle op: pc_en is low for exactly MC_LAT consecutive cycles (the RUN detect cycle plus MC_LAT-1 MC cycles). The DONE cycle has all enables high and the op advances to MEM.
- HALT entry: enables drop in the same cycle halt_req is seen in RUN or DONE. Exit: enables return the cycle after resume.
- rst during MC or HALT aborts immediately to RUN. Held pipeline contents are not touched by this block.

## Test plan
- Reset with quiet inputs → pc_en = ifid_en = idex_en = exmem_en = 1, clears 0, state 0, both counters 0.
- ex_mem_read = 1, ex_rd = 5, id_rs = 5, id_use_rs = 1 for one cycle:
  - → pc_en = ifid_en = 0, idex_clr = 1 for 1 cycle; stall_cnt = 1.
  - Same stimulus with ex_rd = 0 → no stall.
- ex_branch_taken together with a load-use match → ifid_clr = idex_clr = 1, pc_en = 1, flush_cnt = 1, stall_cnt unchanged.
- MC_LAT = 4, ex_mc_start held high:
  - → enables low for exactly 4 cycles, state sequence RUN, MC, MC, MC, DONE, RUN.
  - No retrigger in DONE; stall_cnt = 4.
- halt_req asserted during MC cycle 2 → MC completes; DONE has enables 0; HALT is entered; resume pulse → RUN next cycle, halted = 0.
- Force stall_cnt to all-ones, then stall → stays all-ones. Assert rst mid-MC → state RUN immediately, counters 0.
